card_regfile_writer: RTL and testbench
======================================

# card_regfile_writer

Initiator side of the card register-file sync chain: holds the state word of every card on the board and, once per trigger, streams one 14-bit word per card onto the shared `regfile_in` bus behind a one-cycle `regfile_sync` token. The block then waits for the token to emerge from the end of the chain as `regfile_sync_done`. It sits between the game logic (which writes card states) and the card drawing chain (which consumes them), and is clocked in the pixel domain.

## Interface
- `NUM_CARDS`, 12, number of cards in the chain; also the number of words streamed per sync.
- `TIMEOUT_CYCLES`, 64, maximum wait for `regfile_sync_done`, counted from the cycle after the last word; range 1..255.
- `pclk`  input  1  pixel clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `frame_start`  input  1  single-cycle trigger to start one sync sequence (typically vblank start).
- `wr_en`  input  1  game-logic write strobe.
- `wr_addr`  input  4  card index 0..NUM_CARDS-1; larger values are ignored.
- `wr_data`  input  14  card word: [13:12] state (00 hidden, 01 revealed, 10 matched, 11 reserved), [11:0] face colour RGB 4:4:4.
- `regfile_sync_done`  input  1  token returned from the last card in the chain.
- `regfile_sync`  output  1  one-cycle token into card 0.
- `regfile_in`  output  14  word for the card currently holding the token.
- `busy`  output  1  sequence in progress.
- `timeout_err`  output  1  sticky watchdog error.

## Operation
- Internal storage: NUM_CARDS x 14-bit entries, all reset to 14'h0000 (hidden, black).
- Write port: when `wr_en` is high and `wr_addr` < NUM_CARDS, the entry is updated at the edge. Writes are accepted in every state.
- Chain contract: card i latches `regfile_in` on the edge where its sync input is high, and pulses its done output one cycle later. The writer therefore presents word i exactly i cycles after asserting `regfile_sync`.
- FSM states and transitions:
  - IDLE: `frame_start`=1 -> STREAM.
  - STREAM: index counter runs 0..NUM_CARDS-1, presenting the entry at the counter's index. After index NUM_CARDS-1 -> WAIT_DONE.
  - WAIT_DONE: `regfile_sync_done`=1 -> IDLE. If the watchdog expires (see Configuration) -> IDLE with `timeout_err` set.
- `frame_start` is ignored outside IDLE; no queuing.
- `regfile_sync_done` is ignored outside WAIT_DONE.
- Write/stream collision: a write to entry k in the same cycle that entry k is being presented streams the old value. The new value appears in the next sequence.
- All outputs are registered.

## Timing
- Reset values: `regfile_sync`=0, `regfile_in`=0, `busy`=0, `timeout_err`=0, FSM=IDLE, index=0, watchdog=0.
- `frame_start` sampled high at edge E0. With S = first cycle after E0:
  - cycle S: `regfile_sync`=1, `regfile_in`=entry0, `busy`=1.
  - cycle S+k (k=1..NUM_CARDS-1): `regfile_sync`=0, `regfile_in`=entry k.
  - from S+NUM_CARDS: `regfile_in`=0.
- A correct chain returns `regfile_sync_done` in cycle S+NUM_CARDS. `busy` falls in the cycle after done is sampled.
- The earliest re-trigger is the cycle after `busy` falls, giving a minimum period of NUM_CARDS+2 cycles.
- Reset asserted mid-sequence: all outputs return to reset values immediately, with no partial token. Storage contents are also cleared.

## Configuration
- `CARD_REGFILE_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES without done, the FSM returns to IDLE and sets `timeout_err`.
  - `timeout_err` stays set until `rst`.
- Not defined:
  - No watchdog; WAIT_DONE waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Write entry i = {2'b01, 12'h100+i} for i=0..11, then pulse `frame_start`, with a 12-stage one-cycle-delay chain model -> sync at S only, words 0x1100..0x110B on S..S+11, done at S+12, `busy` low at S+13.
- Write `wr_addr`=5 with 14'h2ABC in cycle S+5 of a sequence -> old entry5 streamed in that sequence; 14'h2ABC streamed at S'+5 of the next sequence.
- `frame_start` pulsed at S+3 and S+12 -> ignored; exactly one sync pulse per sequence. `wr_addr`=12 write -> no entry changes.
- Macro defined, chain model never returns done -> `timeout_err`=1 after 64 WAIT_DONE cycles, FSM in IDLE, a new `frame_start` still streams. Macro undefined, same stimulus -> `busy` stays 1 and `timeout_err`=0.
- `rst` asserted at S+6 -> `regfile_sync`, `regfile_in`, `busy` = 0 immediately. After release, all entries read back 0 on the next sequence.

Source files
------------

// File: rtl/card_regfile_writer.sv
// card_regfile_writer
// Initiator end of the card register-file sync chain. Holds one 14-bit state
// word per card and, on each frame_start, streams every word onto regfile_in
// behind a single-cycle regfile_sync token, then waits for the token to come
// back out of the chain as regfile_sync_done.
//
// Optional feature macro: CARD_REGFILE_TIMEOUT_EN
//   defined   -> an 8-bit watchdog bounds the wait for regfile_sync_done and
//                raises a sticky timeout_err when it expires.
//   undefined -> the writer waits for regfile_sync_done indefinitely and
//                timeout_err is tied low.

module card_regfile_writer #(
    parameter int NUM_CARDS      = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [13:0] wr_data,
    input  logic        regfile_sync_done,
    output logic        regfile_sync,
    output logic [13:0] regfile_in,
    output logic        busy,
    output logic        timeout_err
);

    // The index has to reach NUM_CARDS itself: that value marks the cycle
    // after the last word, where the bus returns to zero.
    localparam int IDX_W = $clog2(NUM_CARDS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               regfile_sync_q;
    logic [13:0]        regfile_in_q;
    logic               busy_q;

    logic [13:0]        mem_q [NUM_CARDS];
    logic               wr_in_range;
    logic [13:0]        stream_word_d;
    logic               idx_at_end;

    assign wr_in_range = ({1'b0, wr_addr} < 5'(NUM_CARDS));
    assign idx_at_end  = (idx_q == IDX_W'(NUM_CARDS));

    // Card state storage: game-logic writes land at the edge in any FSM state.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CARDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Word selected for the next streamed cycle; a same-cycle write is not
    // visible here yet, so a colliding write streams the old value.
    always_comb begin
        stream_word_d = '0;
        if (!idx_at_end) begin
            stream_word_d = mem_q[idx_q];
        end
    end

`ifdef CARD_REGFILE_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q;
    logic [7:0] wdog_d;
    logic       wdog_expired;
    logic       timeout_err_q;

    assign wdog_expired = (state_q == WAIT_DONE) && !regfile_sync_done
                          && (wdog_q == WDOG_LIMIT);

    // Watchdog next value: counts only while waiting without a token.
    always_comb begin
        wdog_d = '0;
        if ((state_q == WAIT_DONE) && !regfile_sync_done && !wdog_expired) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    // Watchdog counter and sticky error flag, cleared only by reset.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (wdog_expired) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_err    = 1'b0;
`endif

    // Sequencer: token, bus word and busy are all registered here so the
    // chain sees word i exactly i cycles after the token.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            regfile_sync_q <= 1'b0;
            regfile_in_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            regfile_sync_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    regfile_in_q <= '0;
                    idx_q        <= '0;
                    if (frame_start) begin
                        state_q        <= STREAM;
                        regfile_sync_q <= 1'b1;
                        regfile_in_q   <= mem_q[0];
                        idx_q          <= IDX_W'(1);
                        busy_q         <= 1'b1;
                    end
                end
                STREAM: begin
                    if (idx_at_end) begin
                        regfile_in_q <= '0;
                        idx_q        <= '0;
                        state_q      <= WAIT_DONE;
                    end else begin
                        regfile_in_q <= stream_word_d;
                        idx_q        <= idx_q + IDX_W'(1);
                    end
                end
                WAIT_DONE: begin
                    regfile_in_q <= '0;
                    if (regfile_sync_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`ifdef CARD_REGFILE_TIMEOUT_EN
                    else if (wdog_expired) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q      <= IDLE;
                    idx_q        <= '0;
                    regfile_in_q <= '0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign regfile_sync = regfile_sync_q;
    assign regfile_in   = regfile_in_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_card_regfile_writer.sv
// Directed testbench for card_regfile_writer with a 12-stage chain model.
module tb_card_regfile_writer;

   logic        pclk;
   logic        rst;
   logic        frameStart;
   logic        wrEn;
   logic [3:0]  wrAddr;
   logic [13:0] wrData;
   logic        syncDone;
   logic        regfileSync;
   logic [13:0] regfileIn;
   logic        busy;
   logic        timeoutErr;

   int testsRun = 0;
   int testsFailed = 0;

   logic [13:0] model [12];
   logic [13:0] snap [12];
   logic [13:0] cardLatch [12];
   logic [11:0] chain;
   logic        chainEnable;
   logic        manualDone;

`ifdef CARD_REGFILE_TIMEOUT_EN
   localparam logic ExpBusyStuck = 1'b0;
   localparam logic ExpTerr      = 1'b1;
`else
   localparam logic ExpBusyStuck = 1'b1;
   localparam logic ExpTerr      = 1'b0;
`endif

   card_regfile_writer dut (
      .pclk              (pclk),
      .rst               (rst),
      .frame_start       (frameStart),
      .wr_en             (wrEn),
      .wr_addr           (wrAddr),
      .wr_data           (wrData),
      .regfile_sync_done (syncDone),
      .regfile_sync      (regfileSync),
      .regfile_in        (regfileIn),
      .busy              (busy),
      .timeout_err       (timeoutErr)
   );

   // Free-running pixel clock.
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Chain model: each card passes the token one cycle later and latches the bus word.
   always @(posedge pclk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[10:0], regfileSync};
         for (int i = 0; i < 12; i++) begin
            if ((i == 0) ? regfileSync : chain[i-1]) begin
               cardLatch[i] <= regfileIn;
            end
         end
      end
   end

   assign syncDone = (chain[11] & chainEnable) | manualDone;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] a, input logic [13:0] d);
      wrEn   = 1'b1;
      wrAddr = a;
      wrData = d;
      @(negedge pclk);
      wrEn = 1'b0;
      if (a < 4'd12) model[a] = d;
   endtask

   task automatic runSequence(input int wrCycle, input logic [3:0] wrA, input logic [13:0] wrD,
                              input int fsA, input int fsB, input int rstCycle, input bit expectDone);
      for (int i = 0; i < 12; i++) snap[i] = model[i];
      frameStart = 1'b1;
      @(negedge pclk);
      frameStart = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         if (k != 0) begin
            @(negedge pclk);
            frameStart = 1'b0;
            wrEn       = 1'b0;
         end
         checkOutput($sformatf("sync@S+%0d", k), 32'(regfileSync), (k == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("word@S+%0d", k), 32'(regfileIn), (k < 12) ? 32'(snap[k]) : 32'd0);
         checkOutput($sformatf("busy@S+%0d", k), 32'(busy), 32'd1);
         if (k == wrCycle) begin
            wrEn   = 1'b1;
            wrAddr = wrA;
            wrData = wrD;
            if (wrA < 4'd12) model[wrA] = wrD;
         end
         if (k == fsA || k == fsB) frameStart = 1'b1;
         if (k == rstCycle) begin
            rst = 1'b1;
            #1;
            checkOutput("rst_sync", 32'(regfileSync), 32'd0);
            checkOutput("rst_word", 32'(regfileIn), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_terr", 32'(timeoutErr), 32'd0);
            @(negedge pclk);
            rst  = 1'b0;
            wrEn = 1'b0;
            for (int i = 0; i < 12; i++) model[i] = '0;
            return;
         end
      end
      if (!expectDone) return;
      @(negedge pclk);
      frameStart = 1'b0;
      wrEn       = 1'b0;
      checkOutput("busy@S+13", 32'(busy), 32'd0);
      checkOutput("sync@S+13", 32'(regfileSync), 32'd0);
      @(negedge pclk);
      checkOutput("sync@S+14", 32'(regfileSync), 32'd0);
      checkOutput("busy@S+14", 32'(busy), 32'd0);
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("card%0d_latch", i), 32'(cardLatch[i]), 32'(snap[i]));
      end
   endtask

   // Directed stimulus, one step after another.
   initial begin
      rst         = 1'b0;
      frameStart  = 1'b0;
      wrEn        = 1'b0;
      wrAddr      = '0;
      wrData      = '0;
      chainEnable = 1'b1;
      manualDone  = 1'b0;
      for (int i = 0; i < 12; i++) model[i] = '0;

      #2 rst = 1'b1;
      #1;
      checkOutput("reset_sync", 32'(regfileSync), 32'd0);
      checkOutput("reset_word", 32'(regfileIn), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_terr", 32'(timeoutErr), 32'd0);
      @(negedge pclk);
      @(negedge pclk);
      rst = 1'b0;
      @(negedge pclk);

      // Words 0x1100..0x110B streamed behind one token.
      for (int i = 0; i < 12; i++) applyStimulus(4'(i), 14'(14'h1100 + i));
      runSequence(-1, 4'd0, 14'd0, -1, -1, -1, 1'b1);

      // Out-of-range addresses must not touch storage.
      applyStimulus(4'd12, 14'h3FFF);
      applyStimulus(4'd15, 14'h3EEE);

      // Collision on entry 5 plus ignored frame_start pulses.
      runSequence(5, 4'd5, 14'h2ABC, 3, 12, -1, 1'b1);
      checkOutput("model_entry5", 32'(model[5]), 32'h2ABC);
      runSequence(-1, 4'd0, 14'd0, -1, -1, -1, 1'b1);

      // Chain never returns the token.
      chainEnable = 1'b0;
      runSequence(-1, 4'd0, 14'd0, -1, -1, -1, 1'b0);
      repeat (63) @(negedge pclk);
      checkOutput("busy@S+75", 32'(busy), 32'd1);
      checkOutput("terr@S+75", 32'(timeoutErr), 32'd0);
      @(negedge pclk);
      checkOutput("busy@S+76", 32'(busy), 32'(ExpBusyStuck));
      checkOutput("terr@S+76", 32'(timeoutErr), 32'(ExpTerr));
      repeat (4) @(negedge pclk);
      checkOutput("busy@S+80", 32'(busy), 32'(ExpBusyStuck));
      checkOutput("terr@S+80", 32'(timeoutErr), 32'(ExpTerr));
      manualDone = 1'b1;
      @(negedge pclk);
      manualDone = 1'b0;
      checkOutput("busy_after_release", 32'(busy), 32'd0);
      chainEnable = 1'b1;
      @(negedge pclk);
      runSequence(-1, 4'd0, 14'd0, -1, -1, -1, 1'b1);
      checkOutput("terr_sticky", 32'(timeoutErr), 32'(ExpTerr));

      // Reset mid-sequence, then storage must read back as zero.
      runSequence(-1, 4'd0, 14'd0, -1, -1, 6, 1'b1);
      @(negedge pclk);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      runSequence(-1, 4'd0, 14'd0, -1, -1, -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Safety net so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
